// File: rtl/word_serializer_16.sv
// Flow-controlled serializer: latches a WIDTH-bit word over valid/ready and
// walks a select counter across it, emitting one bit per accepted handshake.
module word_serializer_16 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_START = LSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_END   = LSB_FIRST ? SEL_W'(WIDTH - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_hold;
  logic [SEL_W-1:0] r_sel;
  logic             w_in_ready;
  logic             w_bit_valid;
  logic             w_at_end;
  logic             w_accept_word;
  logic             w_accept_bit;

  assign w_at_end      = (r_sel == SEL_END);
  assign w_accept_word = in_valid && w_in_ready;
  assign w_accept_bit  = w_bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_word)             w_next_state = S_SHIFT;
      S_SHIFT: if (w_accept_bit && w_at_end)  w_next_state = S_IDLE;
      default:                                w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs are forced low while rst is asserted, regardless of state.
  always_comb begin
    w_in_ready  = 1'b0;
    w_bit_valid = 1'b0;
    if (!rst) begin
      w_in_ready  = (r_state == S_IDLE);
      w_bit_valid = (r_state == S_SHIFT);
    end
  end

  assign in_ready  = w_in_ready;
  assign bit_valid = w_bit_valid;
  assign busy      = w_bit_valid;
  assign sel       = r_sel;
  assign bit_out   = w_bit_valid && r_hold[r_sel];
  assign bit_last  = w_bit_valid && w_at_end;

  // The final accepted bit parks sel back at START so IDLE always shows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_sel  <= SEL_START;
    end else if (w_accept_word) begin
      r_hold <= in_data;
      r_sel  <= SEL_START;
    end else if (w_accept_bit) begin
      if (w_at_end) begin
        r_sel <= SEL_START;
      end else if (LSB_FIRST) begin
        r_sel <= r_sel + 1'b1;
      end else begin
        r_sel <= r_sel - 1'b1;
      end
    end
  end

endmodule
